// File: rtl/fsab_bram_responder_pkg.sv
// rtl/fsab_bram_responder_pkg.sv - FSAB widths, encodings and shared types for the BRAM responder
package fsab_bram_responder_pkg;

    localparam int FSAB_REQ_HI          = 0;
    localparam int FSAB_DID_HI          = 3;
    localparam int FSAB_ADDR_HI         = 31;
    localparam int FSAB_LEN_HI          = 3;
    localparam int FSAB_INITIAL_CREDITS = 4;
    localparam int FSAB_MAX_LEN         = 8;

    localparam logic [FSAB_REQ_HI:0] FSAB_READ  = 1'b0;
    localparam logic [FSAB_REQ_HI:0] FSAB_WRITE = 1'b1;

    localparam logic [FSAB_LEN_HI:0] FSAB_MAX_LEN_F = 4'd8;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_WR   = 2'd1,
        ENG_RD   = 2'd2
    } eng_state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  mask;
    } fsab_beat_t;

    // Header as queued; the word address is appended separately because its
    // width depends on the memory depth parameter.
    typedef struct packed {
        logic [FSAB_REQ_HI:0] mode;
        logic [FSAB_DID_HI:0] did;
        logic [FSAB_DID_HI:0] subdid;
        logic [FSAB_LEN_HI:0] len;
    } fsab_hdr_t;

    // len = 0 means a full burst; anything above the maximum is clamped.
    function automatic logic [FSAB_LEN_HI:0] fsab_eff_len(input logic [FSAB_LEN_HI:0] len);
        return ((len == '0) || (len > FSAB_MAX_LEN_F)) ? FSAB_MAX_LEN_F : len;
    endfunction

endpackage

// File: rtl/fsab_sync_fifo.sv
// rtl/fsab_sync_fifo.sv - single-clock FIFO with registered storage and show-ahead output
// Ports: clk, rst_b (async, active low); push/din write side; pop/dout read side;
//        full/empty status. DEPTH must be a power of 2.
module fsab_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // Push on a full FIFO is only legal when a pop frees the slot that cycle.
    always @(posedge clk) begin
        if (rst_b) begin
            assert (!(push && full && !pop)) else $error("fsab_sync_fifo: push while full");
            assert (!(pop && empty)) else $error("fsab_sync_fifo: pop while empty");
        end
    end

endmodule

// File: rtl/fsab_bram_responder.sv
// rtl/fsab_bram_responder.sv - FSAB target serving reads/writes from an on-chip 64-bit block RAM
// Ports: clk, rst_b (async, active low)
//        fsabo_*  request side: valid, mode, did, subdid, addr, len, data, mask; credit pulse back
//        fsabi_*  response side: valid, did, subdid, data
module fsab_bram_responder
    import fsab_bram_responder_pkg::*;
#(
    parameter int MEM_WORDS = 2048,
    parameter int REQ_DEPTH = FSAB_INITIAL_CREDITS
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  fsabo_valid,
    input  logic [FSAB_REQ_HI:0]  fsabo_mode,
    input  logic [FSAB_DID_HI:0]  fsabo_did,
    input  logic [FSAB_DID_HI:0]  fsabo_subdid,
    input  logic [FSAB_ADDR_HI:0] fsabo_addr,
    input  logic [FSAB_LEN_HI:0]  fsabo_len,
    input  logic [63:0]           fsabo_data,
    input  logic [7:0]            fsabo_mask,
    output logic                  fsabo_credit,
    output logic                  fsabi_valid,
    output logic [FSAB_DID_HI:0]  fsabi_did,
    output logic [FSAB_DID_HI:0]  fsabi_subdid,
    output logic [63:0]           fsabi_data
);

    localparam int MEM_HI = $clog2(MEM_WORDS) - 1;
    localparam int AW     = MEM_HI + 1;
    localparam int HDR_W  = $bits(fsab_hdr_t) + AW;
    localparam int IDX_W  = $clog2(FSAB_MAX_LEN);

    // ---------------- ingress ----------------
    logic                 in_burst_q;
    logic [FSAB_LEN_HI:0] remain_q;
    logic                 is_hdr;
    logic [FSAB_LEN_HI:0] ing_len;
    fsab_hdr_t            hdr_in;
    logic                 hdr_push;
    logic                 dat_push;
    fsab_beat_t           dat_in;

    assign is_hdr   = fsabo_valid && !in_burst_q;
    assign ing_len  = fsab_eff_len(fsabo_len);
    assign hdr_push = is_hdr;
    // Mode is only meaningful on the header beat; continuation beats are always write data.
    assign dat_push = fsabo_valid && (in_burst_q || (fsabo_mode == FSAB_WRITE));

    always_comb begin
        hdr_in        = '0;
        hdr_in.mode   = fsabo_mode;
        hdr_in.did    = fsabo_did;
        hdr_in.subdid = fsabo_subdid;
        hdr_in.len    = ing_len;
        dat_in        = '0;
        dat_in.data   = fsabo_data;
        dat_in.mask   = fsabo_mask;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            in_burst_q <= 1'b0;
            remain_q   <= '0;
        end else if (is_hdr) begin
            if ((fsabo_mode == FSAB_WRITE) && (ing_len > 4'd1)) begin
                in_burst_q <= 1'b1;
                remain_q   <= ing_len - 4'd1;
            end
        end else if (in_burst_q && fsabo_valid) begin
            remain_q <= remain_q - 4'd1;
            if (remain_q == 4'd1) in_burst_q <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_b && is_hdr) begin
            assert (!(fsabo_len > FSAB_MAX_LEN_F)) else $error("fsab_bram_responder: len > 8");
        end
    end

    // Address bits below the word and above the memory depth do not select anything.
    logic unused_addr_bits;
    generate
        if (FSAB_ADDR_HI > MEM_HI + 3) begin : g_addr_hi
            assign unused_addr_bits = ^{fsabo_addr[2:0], fsabo_addr[FSAB_ADDR_HI:MEM_HI+4]};
        end else begin : g_addr_lo
            assign unused_addr_bits = ^fsabo_addr[2:0];
        end
    endgenerate

    // ---------------- queues ----------------
    logic [HDR_W-1:0] hdr_dout;
    logic             hdr_pop;
    logic             hdr_full;
    logic             hdr_empty;
    fsab_hdr_t        hdr_out;
    logic [AW-1:0]    hdr_addr_out;

    fsab_beat_t       dat_dout;
    logic             dat_pop;
    logic             dat_full;
    logic             dat_empty;

    fsab_sync_fifo #(
        .WIDTH (HDR_W),
        .DEPTH (REQ_DEPTH)
    ) u_hdr_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (hdr_push),
        .din   ({hdr_in, fsabo_addr[MEM_HI+3:3]}),
        .pop   (hdr_pop),
        .dout  (hdr_dout),
        .full  (hdr_full),
        .empty (hdr_empty)
    );

    fsab_sync_fifo #(
        .WIDTH ($bits(fsab_beat_t)),
        .DEPTH (REQ_DEPTH * FSAB_MAX_LEN)
    ) u_dat_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (dat_push),
        .din   (dat_in),
        .pop   (dat_pop),
        .dout  (dat_dout),
        .full  (dat_full),
        .empty (dat_empty)
    );

    assign {hdr_out, hdr_addr_out} = hdr_dout;

    // Full flags are only observed by the overflow assertions inside the FIFOs.
    logic unused_full;
    assign unused_full = hdr_full ^ dat_full;

    // ---------------- engine ----------------
    eng_state_t           state_q;
    eng_state_t           state_d;
    logic [AW-1:0]        base_q;
    logic [FSAB_LEN_HI:0] len_q;
    logic [IDX_W-1:0]     idx_q;
    logic [FSAB_DID_HI:0] did_q;
    logic [FSAB_DID_HI:0] subdid_q;
    logic                 beat_last;
    logic                 ram_we;
    logic                 ram_re;
    logic                 done;
    logic [AW-1:0]        ram_addr;

    assign beat_last = ({1'b0, idx_q} == (len_q - 4'd1));
    // Wraps modulo MEM_WORDS through natural truncation.
    assign ram_addr  = base_q + AW'(idx_q);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= ENG_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        hdr_pop = 1'b0;
        dat_pop = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ENG_IDLE: begin
                if (!hdr_empty) begin
                    hdr_pop = 1'b1;
                    state_d = (hdr_out.mode == FSAB_WRITE) ? ENG_WR : ENG_RD;
                end
            end
            ENG_WR: begin
                // Stall rather than skip when the next data beat has not arrived yet.
                if (!dat_empty) begin
                    dat_pop = 1'b1;
                    ram_we  = 1'b1;
                    if (beat_last) begin
                        done    = 1'b1;
                        state_d = ENG_IDLE;
                    end
                end
            end
            ENG_RD: begin
                ram_re = 1'b1;
                if (beat_last) begin
                    done    = 1'b1;
                    state_d = ENG_IDLE;
                end
            end
            default: state_d = ENG_IDLE;
        endcase
    end

    logic                 rsp_valid_q;
    logic [FSAB_DID_HI:0] rsp_did_q;
    logic [FSAB_DID_HI:0] rsp_subdid_q;
    logic                 credit_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            base_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            did_q        <= '0;
            subdid_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_did_q    <= '0;
            rsp_subdid_q <= '0;
            credit_q     <= 1'b0;
        end else begin
            if (hdr_pop) begin
                base_q   <= hdr_addr_out;
                len_q    <= hdr_out.len;
                did_q    <= hdr_out.did;
                subdid_q <= hdr_out.subdid;
                idx_q    <= '0;
            end else if (dat_pop || ram_re) begin
                idx_q <= idx_q + 1'b1;
            end
            // Response and credit are delayed one cycle to line up with the RAM read latency.
            rsp_valid_q <= ram_re;
            if (ram_re) begin
                rsp_did_q    <= did_q;
                rsp_subdid_q <= subdid_q;
            end
            credit_q <= done;
        end
    end

    // ---------------- RAM ----------------
    logic [63:0] mem [MEM_WORDS];
    logic [63:0] ram_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 8; b++) begin
                if (dat_dout.mask[b]) mem[ram_addr][b*8 +: 8] <= dat_dout.data[b*8 +: 8];
            end
        end
        if (ram_re) ram_q <= mem[ram_addr];
    end

    assign fsabo_credit = credit_q;
    assign fsabi_valid  = rsp_valid_q;
    assign fsabi_did    = rsp_did_q;
    assign fsabi_subdid = rsp_subdid_q;
    assign fsabi_data   = rsp_valid_q ? ram_q : 64'd0;

endmodule
